ccu_cmd_sequencer: RTL

//  Issues the 8-bit command stream that the CCU decodes onto its 24-bit K bus.

---
 rtl/ccu_cmd_sequencer_pkg.sv | 22 ++
 rtl/ccu_cmd_fifo.sv | 80 ++++++++
 rtl/ccu_cmd_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ccu_cmd_sequencer_pkg.sv
// Shared definitions for the CCU command sequencer: widths, the idle command,
// a few CCU opcodes and the sequencer state encoding.
package ccu_cmd_sequencer_pkg;

  localparam int CCU_CMD_W = 8;
  localparam int CCU_CNT_W = 4;
  localparam int CCU_DEPTH = 4;

  localparam logic [CCU_CMD_W-1:0] CCU_NOP_CMD = 8'd0;

  // Opcodes the CCU decodes onto its K bus; the sequencer passes them through untouched.
  localparam logic [CCU_CMD_W-1:0] CCU_OP_LOAD  = 8'd2;
  localparam logic [CCU_CMD_W-1:0] CCU_OP_STORE = 8'd4;
  localparam logic [CCU_CMD_W-1:0] CCU_OP_ADD   = 8'd6;
  localparam logic [CCU_CMD_W-1:0] CCU_OP_SHIFT = 8'd8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_e;

endpackage

// File: rtl/ccu_cmd_fifo.sv
// Synchronous FIFO of packed {cmd, rep} entries with an occupancy counter.
// Pointers wrap naturally because DEPTH is a power of two.
module ccu_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Guard against over/underflow here so callers can stay simple.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/ccu_cmd_sequencer.sv
// Feeds queued {cmd, rep} entries to the CCU, holding each command for rep+1
// clocks and falling back to NOP_CMD whenever nothing is queued.
module ccu_cmd_sequencer
  import ccu_cmd_sequencer_pkg::*;
#(
  parameter int               CMD_W   = CCU_CMD_W,
  parameter int               CNT_W   = CCU_CNT_W,
  parameter int               DEPTH   = CCU_DEPTH,
  parameter logic [CMD_W-1:0] NOP_CMD = CMD_W'(CCU_NOP_CMD)
) (
  input  logic                         clk,
  input  logic                         rst,
  // Handshake: an entry transfers on any rising edge where in_valid && in_ready;
  // while in_ready is low the source keeps in_valid, in_cmd and in_rep stable.
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CMD_W-1:0]             in_cmd,
  input  logic [CNT_W-1:0]             in_rep,
  input  logic                         flush,
  output logic [CMD_W-1:0]             cmd,
  output logic                         cmd_valid,
  output logic                         done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         state_dbg
);

  localparam int ENT_W = CMD_W + CNT_W;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;

  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;
  logic [CMD_W-1:0] head_cmd;
  logic [CNT_W-1:0] head_rep;
  logic             last_hold;

  assign push                 = in_valid && in_ready;
  assign {head_cmd, head_rep} = head;
  assign last_hold            = (state_q == ST_ISSUE) && (cnt_q == '0);

  ccu_cmd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data ({in_cmd, in_rep}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= NOP_CMD;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  // Loading from the head on the last hold cycle gives back-to-back issue with no NOP gap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    pop         = 1'b0;
    if (flush) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      cmd_d       = NOP_CMD;
      cmd_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            state_d     = ST_ISSUE;
            cmd_d       = head_cmd;
            cnt_d       = head_rep;
            cmd_valid_d = 1'b1;
          end
        end
        ST_ISSUE: begin
          if (!last_hold) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (!fifo_empty) begin
            pop         = 1'b1;
            cmd_d       = head_cmd;
            cnt_d       = head_rep;
            cmd_valid_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            cmd_d       = NOP_CMD;
            cmd_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          cmd_d       = NOP_CMD;
          cmd_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    in_ready  = !fifo_full && !flush;
    done      = last_hold && !flush;
    busy      = (state_q == ST_ISSUE) || !fifo_empty;
    cmd       = cmd_q;
    cmd_valid = cmd_valid_q;
    state_dbg = state_q;
  end

endmodule
